// File: rtl/skew_feeder_pkg.sv
// Shared types for the skewed systolic-array feeder.
package skew_feeder_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/feeder_lane.sv
// One feeder row: diagonal window compare plus the zero-filled output register.
module feeder_lane #(
  parameter int WORD_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int LANE_IDX   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [LEN_WIDTH:0]    i_t,
  input  logic [LEN_WIDTH:0]    i_len,
  input  logic                  i_adv,
  input  logic [WORD_WIDTH-1:0] i_word,
  output logic                  o_active,
  output logic [WORD_WIDTH-1:0] o_pe_data,
  output logic                  o_pe_valid
);
  localparam logic [LEN_WIDTH:0] LO = (LEN_WIDTH+1)'(LANE_IDX);

  // LO + len tops out at 2*2**LEN_WIDTH-1, so the extra bit never wraps.
  logic [LEN_WIDTH:0]    w_hi;
  logic [WORD_WIDTH-1:0] r_data;
  logic                  r_valid;

  assign w_hi       = LO + i_len;
  assign o_active   = (i_t >= LO) && (i_t < w_hi);
  assign o_pe_data  = r_data;
  assign o_pe_valid = r_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_adv) begin
      r_valid <= o_active;
      r_data  <= o_active ? i_word : '0;
    end else begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end
  end
endmodule

// File: rtl/skew_feeder.sv
// Drains the row FIFOs into the array's west edge, lane i delayed i cycles.
module skew_feeder
  import skew_feeder_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [LEN_WIDTH-1:0]        vec_len,
  input  logic [LANES-1:0]            fifo_empty,
  input  logic [LANES*WORD_WIDTH-1:0] fifo_data,
  input  logic                        stall,
  output logic [LANES-1:0]            fifo_r_enable,
  output logic [LANES*WORD_WIDTH-1:0] pe_data,
  output logic [LANES-1:0]            pe_valid,
  output logic                        busy,
  output logic                        done
);
  state_t               r_state, w_next;
  logic [LEN_WIDTH:0]   r_t;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LANES-1:0]     w_active;
  logic                 w_adv, w_last;

  // One stalled or starved active lane freezes every lane so the skew stays intact.
  assign w_adv  = (r_state == S_RUN) && !stall && !(|(w_active & fifo_empty));
  assign w_last = (r_t + 1'b1) == ({1'b0, r_len} + (LEN_WIDTH+1)'(LANES-1));
  assign fifo_r_enable = {LANES{w_adv}} & w_active;
  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (vec_len != '0) ? S_RUN : S_DONE;
      S_RUN:   if (w_adv && w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_t     <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start && vec_len != '0) begin
        r_len <= vec_len;
        r_t   <= '0;
      end else if (w_adv) begin
        r_t <= r_t + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    feeder_lane #(
      .WORD_WIDTH(WORD_WIDTH),
      .LEN_WIDTH (LEN_WIDTH),
      .LANE_IDX  (i)
    ) u_lane (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_t       (r_t),
      .i_len     ({1'b0, r_len}),
      .i_adv     (w_adv),
      .i_word    (fifo_data[i*WORD_WIDTH +: WORD_WIDTH]),
      .o_active  (w_active[i]),
      .o_pe_data (pe_data[i*WORD_WIDTH +: WORD_WIDTH]),
      .o_pe_valid(pe_valid[i])
    );
  end
endmodule

// File: tb/tb_skew_feeder.sv
// Scoreboard bench: FIFO model feeds the DUT, a burst tracker predicts every output.
module tb_skew_feeder;
  localparam int W = 8, LANES = 4, LW = 8;
  typedef logic [W-1:0] wq_t[$];

  logic clk = 0, reset_n = 0, start = 0, stall = 0;
  logic [LW-1:0]        vec_len = '0;
  logic [LANES-1:0]     fifo_empty, fifo_r_enable, pe_valid;
  logic [LANES*W-1:0]   fifo_data, pe_data;
  logic                 busy, done;

  skew_feeder #(.WORD_WIDTH(W), .LANES(LANES), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .vec_len(vec_len),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .stall(stall),
    .fifo_r_enable(fifo_r_enable), .pe_data(pe_data), .pe_valid(pe_valid),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_done = 0, n_exp_done = 0;
  bit seen_done = 0;
  wq_t fq[LANES];     // FIFO contents seen by the DUT
  wq_t exp_q[LANES];  // words still expected on each array row

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction

  function automatic logic [LANES-1:0] act_mask(int k, int len);
    logic [LANES-1:0] m = '0;
    for (int i = 0; i < LANES; i++) m[i] = (k >= i) && (k < i + len);
    return m;
  endfunction

  function automatic void refresh();
    for (int i = 0; i < LANES; i++) begin
      fifo_empty[i] = (fq[i].size() == 0);
      fifo_data[i*W +: W] = fifo_empty[i] ? W'($urandom) : fq[i][0];
    end
  endfunction

  // FIFO model: pop requests sampled mid-cycle, applied just after the edge.
  logic [LANES-1:0] pop_mask = '0;
  always @(negedge clk) pop_mask = fifo_r_enable;
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < LANES; i++)
      if (pop_mask[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    pop_mask = '0;
    refresh();
  end

  // Burst tracker: k counts advancing beats of the current burst.
  logic [LANES-1:0] e_valid = '0, e_ren, n_valid;
  logic e_busy = 0, e_done = 0, n_busy, n_done_e;
  int m_len = 0, m_k = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_pe_valid", pe_valid, 0);
      chk("rst_pe_data", pe_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ren", fifo_r_enable, 0);
      e_valid = '0; e_busy = 0; e_done = 0; m_k = 0;
    end else begin
      chk("pe_valid", pe_valid, e_valid);
      for (int i = 0; i < LANES; i++) begin
        if (e_valid[i]) begin
          chk("scoreboard_has_word", exp_q[i].size() > 0, 1);
          if (exp_q[i].size() > 0) chk("pe_data", pe_data[i*W +: W], exp_q[i].pop_front());
        end else chk("bubble_zero", pe_data[i*W +: W], 0);
      end
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      if (done) begin n_done++; seen_done = 1; end
      e_ren = '0; n_valid = '0; n_busy = e_busy; n_done_e = 0;
      if (e_busy) begin
        if (!stall && !(|(act_mask(m_k, m_len) & fifo_empty))) begin
          e_ren = act_mask(m_k, m_len);
          n_valid = e_ren;
          m_k++;
          if (m_k == m_len + LANES - 1) begin n_busy = 0; n_done_e = 1; end
        end
      end else if (!e_done && start) begin
        m_len = int'(vec_len); m_k = 0;
        if (m_len == 0) n_done_e = 1; else n_busy = 1;
      end
      chk("fifo_r_enable", fifo_r_enable, e_ren);
      e_valid = n_valid; e_busy = n_busy; e_done = n_done_e;
    end
  end

  task automatic tick(); @(posedge clk); #2; endtask
  task automatic load(int l, logic [W-1:0] w);
    fq[l].push_back(w); exp_q[l].push_back(w);
  endtask
  task automatic fire(int len, bit counted);
    seen_done = 0; refresh();
    start = 1; vec_len = LW'(len); tick(); start = 0;
    if (counted) n_exp_done++;
  endtask
  task automatic wait_done(int maxc, bit rnd);
    for (int c = 0; c < maxc && !seen_done; c++) begin
      stall = rnd ? ($urandom_range(3) == 0) : 1'b0;
      tick();
    end
    stall = 0;
    chk("done_within_bound", seen_done, 1);
  endtask
  task automatic load_all(int len, bit seq);
    for (int i = 0; i < LANES; i++)
      for (int j = 0; j < len; j++) load(i, seq ? W'(10*i + j + 1) : W'($urandom));
  endtask
  task automatic flush();
    for (int i = 0; i < LANES; i++) begin fq[i].delete(); exp_q[i].delete(); end
    refresh();
  endtask

  initial begin
    refresh();
    repeat (2) tick();
    reset_n = 1; tick();

    // basic burst, then same burst with a two-cycle stall
    load_all(3, 1); fire(3, 1); wait_done(20, 0);
    chk("fifos_drained", fifo_empty, {LANES{1'b1}});
    load_all(3, 1); fire(3, 1); tick(); stall = 1; tick(); tick(); stall = 0;
    wait_done(20, 0);

    // lane 1 starves mid-burst; refilled after a long hold
    for (int i = 0; i < LANES; i++) load(i, W'(50 + i));
    for (int i = 0; i < LANES; i++) if (i != 1) load(i, W'(60 + i));
    fire(2, 1); repeat (8) tick();
    chk("hold_busy", busy, 1);
    load(1, 8'd99); refresh();
    wait_done(20, 0);
    chk("hold_drained", fifo_empty, {LANES{1'b1}});

    // zero length, then a start pulsed during a running burst
    fire(0, 1); wait_done(5, 0);
    load_all(3, 0); fire(3, 1); tick();
    start = 1; vec_len = 8'd7; tick(); start = 0;
    wait_done(20, 0); repeat (3) tick();

    // asynchronous reset mid-burst, then a clean burst
    load_all(5, 0); fire(5, 0); tick(); tick();
    #1 reset_n = 0; #1;
    chk("async_pe_valid", pe_valid, 0);
    chk("async_pe_data", pe_data, 0);
    chk("async_busy", busy, 0);
    chk("async_ren", fifo_r_enable, 0);
    tick(); flush(); tick(); reset_n = 1; tick();
    load_all(5, 0); fire(5, 1); wait_done(30, 0);

    // maximum length burst with random stalls
    load_all(255, 0); fire(255, 1); wait_done(600, 1);
    chk("max_drained", fifo_empty, {LANES{1'b1}});

    // random bursts
    for (int b = 0; b < 25; b++) begin
      load_all($urandom_range(20, 1), 0);
      fire(fq[0].size(), 1); wait_done(200, 1);
      tick();
    end
    chk("done_count", n_done, n_exp_done);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
